// File: rtl/terminal_qsys_led_ctrl.sv
// Avalon-MM LED/channel controller: per-channel on/off, blink and global PWM brightness.
// Output is registered from the register/counter state of the previous cycle.
module terminal_qsys_led_ctrl #(
    parameter int WIDTH     = 10,
    parameter int DIV_W     = 24,
    parameter int DIV_RESET = 2499999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_MODE   = 3'd1;
    localparam logic [2:0] A_SET    = 3'd2;
    localparam logic [2:0] A_CLEAR  = 3'd3;
    localparam logic [2:0] A_TOGGLE = 3'd4;
    localparam logic [2:0] A_DIV    = 3'd5;
    localparam logic [2:0] A_BRIGHT = 3'd6;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] mode_reg;
    logic [DIV_W-1:0] blink_div;
    logic [7:0]       bright;
    logic [DIV_W-1:0] presc_cnt;
    logic             blink_phase;
    logic [7:0]       pwm_cnt;
    logic             pwm_on;
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign pwm_on    = (pwm_cnt < bright);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
            mode_reg <= '0;
            bright   <= 8'd255;
        end else if (wr) begin
            case (address)
                A_DATA:   data_reg <= wd;
                A_MODE:   mode_reg <= wd;
                A_SET:    data_reg <= data_reg | wd;
                A_CLEAR:  data_reg <= data_reg & ~wd;
                A_TOGGLE: data_reg <= data_reg ^ wd;
                A_BRIGHT: bright   <= writedata[7:0];
                default:  ;
            endcase
        end
    end

    // A BLINK_DIV write restarts the blink cycle in the high phase and wins over a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_div   <= DIV_W'(DIV_RESET);
            presc_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr && address == A_DIV) begin
            blink_div   <= writedata[DIV_W-1:0];
            presc_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (presc_cnt >= blink_div) begin
            presc_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            presc_cnt   <= presc_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            pwm_cnt <= '0;
        else if (pwm_cnt == 8'd254)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            out_port <= '0;
        else
            out_port <= data_reg & (blink_phase ? {WIDTH{1'b1}} : ~mode_reg)
                        & {WIDTH{pwm_on}};
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata[WIDTH-1:0] = data_reg;
            A_MODE:   readdata[WIDTH-1:0] = mode_reg;
            A_DIV:    readdata[DIV_W-1:0] = blink_div;
            A_BRIGHT: readdata[7:0]       = bright;
            default:  readdata = '0;
        endcase
    end

endmodule
